// File: rtl/instr_fetch_sequencer.sv
// Program sequencer for the 8-bit CPU: owns the PC, fetches ROM words and
// presents one instruction per three cycles to the decoder.
module instr_fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               sel_pc,
    input  logic               sel_br,
    input  logic [ADDR_W-1:0]  PC_IN,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [3:0]         opcode,
    output logic [7:0]         K,
    output logic               instr_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    // One-hot so instr_valid is a single flop bit.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FETCH = 4'b0010,
        LATCH = 4'b0100,
        EXEC  = 4'b1000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [ADDR_W-1:0]  pc_next;
    logic               halt_hit;

    always_comb begin
        pc_next = pc_q + ADDR_W'(1);
        if (sel_pc) begin
            pc_next = PC_IN;
        end else if (sel_br) begin
            pc_next = pc_q + ADDR_W'(2);
        end
    end

    assign halt_hit = sel_pc && (PC_IN == pc_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        unique case (1'b1)
            state_q[0]: begin
                if (run && !halted_q) begin
                    state_d = FETCH;
                end
            end
            state_q[1]: begin
                state_d = LATCH;
            end
            state_q[2]: begin
                ir_d    = rom_data;
                state_d = EXEC;
            end
            state_q[3]: begin
                if (retired_q != CNT_MAX) begin
                    retired_d = retired_q + CNT_W'(1);
                end
                if (halt_hit) begin
                    halted_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    pc_d    = pc_next;
                    state_d = run ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign pc          = pc_q;
    assign rom_addr    = pc_q;
    assign opcode      = ir_q[INSTR_W-1 -: 4];
    assign K           = ir_q[7:0];
    assign instr_valid = state_q[3];
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer; a second narrow-counter
// instance exercises retired-count saturation.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, run, sel_pc, sel_br;
    logic [7:0]  pc_in;
    logic [11:0] rom_data;
    logic [7:0]  rom_addr, pc;
    logic [3:0]  opcode;
    logic [7:0]  k_op;
    logic        instr_valid, halted;
    logic [15:0] retired;

    logic        rst2_n, run2, sel_pc2, sel_br2;
    logic [7:0]  pc_in2;
    logic [11:0] rom_data2;
    logic [7:0]  rom_addr2, pc2;
    logic [3:0]  opcode2;
    logic [7:0]  k_op2;
    logic        instr_valid2, halted2;
    logic [1:0]  retired2;

    logic [11:0] rom [256];

    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data2 <= rom[rom_addr2];

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .rom_data(rom_data),
        .sel_pc(sel_pc), .sel_br(sel_br), .PC_IN(pc_in),
        .rom_addr(rom_addr), .pc(pc), .opcode(opcode), .K(k_op),
        .instr_valid(instr_valid), .halted(halted), .retired(retired)
    );

    instr_fetch_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .run(run2), .rom_data(rom_data2),
        .sel_pc(sel_pc2), .sel_br(sel_br2), .PC_IN(pc_in2),
        .rom_addr(rom_addr2), .pc(pc2), .opcode(opcode2), .K(k_op2),
        .instr_valid(instr_valid2), .halted(halted2), .retired(retired2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec();
        int guard = 0;
        while (!instr_valid && guard < 12) begin
            tick();
            guard++;
        end
        n_checks++;
        if (instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL exec_timeout: instr_valid=%b required 1", instr_valid);
        end
    endtask

    // Drive decoder response for the current EXEC cycle, then commit.
    task automatic respond(input logic jp, input logic br, input logic [7:0] tgt);
        sel_pc = jp;
        sel_br = br;
        pc_in  = tgt;
        tick();
        sel_pc = 1'b0;
        sel_br = 1'b0;
        pc_in  = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        tick();
        tick();
        n_checks++;
        if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h required 00", pc); end
        n_checks++;
        if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %h required 00", rom_addr); end
        n_checks++;
        if ({opcode, k_op} !== 12'h000) begin n_fail++; $display("FAIL reset_ir: got %h%h required 000", opcode, k_op); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b required 0", halted); end
        n_checks++;
        if (retired !== 16'h0000) begin n_fail++; $display("FAIL reset_retired: got %h required 0000", retired); end
    endtask

    task automatic test_basic();
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fetch_valid: got %b required 0", instr_valid); end
        tick();
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latch_valid: got %b required 0", instr_valid); end
        tick();
        n_checks++;
        if ({instr_valid, opcode, k_op} !== 13'h1F05) begin
            n_fail++; $display("FAIL basic_exec0: got v=%b %h%h required v=1 F05", instr_valid, opcode, k_op);
        end
        respond(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (pc !== 8'h01 || retired !== 16'd1) begin
            n_fail++; $display("FAIL basic_pc1: got pc=%h ret=%0d required pc=01 ret=1", pc, retired);
        end
        tick();
        tick();
        n_checks++;
        if ({instr_valid, opcode, k_op} !== 13'h1107) begin
            n_fail++; $display("FAIL basic_exec1: got v=%b %h%h required v=1 107", instr_valid, opcode, k_op);
        end
        respond(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (pc !== 8'h02 || retired !== 16'd2) begin
            n_fail++; $display("FAIL basic_pc2: got pc=%h ret=%0d required pc=02 ret=2", pc, retired);
        end
    endtask

    task automatic test_jump();
        logic [15:0] r0;
        wait_exec();
        respond(1'b0, 1'b0, 8'h00);
        wait_exec();
        n_checks++;
        if (pc !== 8'h03) begin n_fail++; $display("FAIL jump_src: got %h required 03", pc); end
        r0 = retired;
        respond(1'b1, 1'b0, 8'h40);
        n_checks++;
        if (rom_addr !== 8'h40 || pc !== 8'h40) begin
            n_fail++; $display("FAIL jump_dst: got addr=%h pc=%h required 40", rom_addr, pc);
        end
        n_checks++;
        if (retired !== r0 + 16'd1) begin
            n_fail++; $display("FAIL jump_retired: got %0d required %0d", retired, r0 + 16'd1);
        end
    endtask

    task automatic test_skip();
        wait_exec();
        respond(1'b1, 1'b0, 8'h10);
        wait_exec();
        respond(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (pc !== 8'h12) begin n_fail++; $display("FAIL skip_10: got %h required 12", pc); end
        wait_exec();
        respond(1'b1, 1'b0, 8'hFE);
        wait_exec();
        respond(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (pc !== 8'h00) begin n_fail++; $display("FAIL skip_fe_wrap: got %h required 00", pc); end
        wait_exec();
        respond(1'b1, 1'b0, 8'hFF);
        wait_exec();
        respond(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (pc !== 8'h01) begin n_fail++; $display("FAIL skip_ff_wrap: got %h required 01", pc); end
        wait_exec();
        respond(1'b1, 1'b0, 8'hFF);
        wait_exec();
        respond(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (pc !== 8'h00) begin n_fail++; $display("FAIL inc_ff_wrap: got %h required 00", pc); end
    endtask

    task automatic test_priority();
        wait_exec();
        respond(1'b1, 1'b0, 8'h05);
        wait_exec();
        respond(1'b1, 1'b1, 8'h20);
        n_checks++;
        if (pc !== 8'h20) begin n_fail++; $display("FAIL jump_priority: got %h required 20", pc); end
    endtask

    task automatic test_run_drop();
        tick();
        run = 1'b0;
        tick();
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL drop_exec: got %b required 1", instr_valid); end
        respond(1'b0, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h21) begin
            n_fail++; $display("FAIL drop_idle: got v=%b pc=%h required v=0 pc=21", instr_valid, pc);
        end
        run = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL drop_resume: got %b required 1", instr_valid); end
        respond(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_halt();
        logic [15:0] r0;
        logic        saw;
        wait_exec();
        respond(1'b1, 1'b0, 8'h08);
        wait_exec();
        r0 = retired;
        respond(1'b1, 1'b0, 8'h08);
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'h08 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_set: got h=%b pc=%h v=%b required h=1 pc=08 v=0", halted, pc, instr_valid);
        end
        n_checks++;
        if (retired !== r0 + 16'd1) begin
            n_fail++; $display("FAIL halt_retired: got %0d required %0d", retired, r0 + 16'd1);
        end
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run = i[0];
            tick();
            saw = saw | instr_valid;
        end
        n_checks++;
        if (saw !== 1'b0 || pc !== 8'h08 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky: got v=%b pc=%h h=%b required v=0 pc=08 h=1", saw, pc, halted);
        end
        run   = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b required 0", halted); end
        tick();
    endtask

    task automatic test_reset_exec();
        rst_n = 1'b1;
        run   = 1'b1;
        wait_exec();
        respond(1'b1, 1'b0, 8'h30);
        wait_exec();
        n_checks++;
        if ({opcode, k_op} !== 12'hA5C) begin n_fail++; $display("FAIL rx_ir: got %h%h required A5C", opcode, k_op); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h00 || retired !== 16'd0) begin
            n_fail++; $display("FAIL rx_async: got v=%b pc=%h ret=%0d required v=0 pc=00 ret=0", instr_valid, pc, retired);
        end
        n_checks++;
        if ({opcode, k_op} !== 12'h000) begin n_fail++; $display("FAIL rx_ir_clr: got %h%h required 000", opcode, k_op); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        logic [1:0] exp;
        int         guard;
        rst2_n = 1'b0;
        tick();
        rst2_n = 1'b1;
        run2   = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            guard = 0;
            while (!instr_valid2 && guard < 12) begin
                tick();
                guard++;
            end
            tick();
            exp = (n > 3) ? 2'd3 : 2'(n);
            n_checks++;
            if (retired2 !== exp) begin
                n_fail++; $display("FAIL sat_retired_%0d: got %0d required %0d", n, retired2, exp);
            end
        end
        run2 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 12'(i * 37 + 5);
        rom[0]     = 12'hF05;
        rom[1]     = 12'h107;
        rom[8'h30] = 12'hA5C;
        sel_pc  = 1'b0;
        sel_br  = 1'b0;
        pc_in   = 8'h00;
        rst2_n  = 1'b0;
        run2    = 1'b0;
        sel_pc2 = 1'b0;
        sel_br2 = 1'b0;
        pc_in2  = 8'h00;
        test_reset();
        test_basic();
        test_jump();
        test_skip();
        test_priority();
        test_run_drop();
        test_halt();
        test_reset_exec();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
